// File: rtl/lreq_arbiter.sv
// lreq_arbiter: shares the PHY link-request serializer among NREQ requesters.
// Latches one-cycle request pulses per requester, picks one round-robin and
// issues a single trigger/type/data triple. It then waits out the serializer
// length for that type plus a fixed gap before issuing the next trigger.
// Optional statistics outputs (grant_cnt, max_wait) are present only when
// LREQ_ARB_STATS_EN is defined.
module lreq_arbiter #(
  parameter int NREQ    = 3,
  parameter int GAP     = 4,
  parameter int LEN_BUS = 8,
  parameter int LEN_RD  = 10,
  parameter int LEN_WR  = 18
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_trig,
  input  logic [3*NREQ-1:0]    req_type,
  input  logic [12*NREQ-1:0]   req_data,
  output logic                 lreq_trig,
  output logic [2:0]           lreq_type,
  output logic [11:0]          lreq_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      pending,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 ovr_clr
`ifdef LREQ_ARB_STATS_EN
  ,
  output logic [15:0]          grant_cnt,
  output logic [7:0]           max_wait
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);
  localparam logic [4:0]  GAP_M1 = (GAP == 0) ? 5'd0 : 5'(GAP - 1);

  // Out-of-range parameters stop elaboration.
  generate
    if (NREQ < 2 || NREQ > 8 || GAP < 0 || GAP > 31 ||
        LEN_BUS < 1 || LEN_BUS > 31 || LEN_RD < 1 || LEN_RD > 31 ||
        LEN_WR < 1 || LEN_WR > 31) begin : g_param_check
      $error("lreq_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SHIFT, S_GAP} state_t;

  state_t          state, state_next;
  logic [4:0]      cnt, cnt_next;
  logic [PW-1:0]   rr_ptr, rr_ptr_next;
  logic [NREQ-1:0] grant_next;
  logic [2:0]      lreq_type_next;
  logic [11:0]     lreq_data_next;

  logic [2:0]      slot_type [NREQ];
  logic [11:0]     slot_data [NREQ];
  logic [2:0]      type_next [NREQ];
  logic [11:0]     data_next [NREQ];
  logic [NREQ-1:0] pend_next;
  logic [NREQ-1:0] ovr_hit;

  logic            can_grant;
  logic            grant_fire;
  logic            sel_valid;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   sel_off;
  logic [PW:0]     sel_sum;
  logic [NREQ-1:0] pend_rot;
  logic [NREQ-1:0] scan;

  // Serializer length minus one for the latched request type.
  function automatic logic [4:0] len_m1(input logic [2:0] t);
    case (t)
      3'd1:    return 5'(LEN_RD - 1);
      3'd2:    return 5'(LEN_WR - 1);
      default: return 5'(LEN_BUS - 1);
    endcase
  endfunction

  // Round-robin pick: rotate pending so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    pend_rot  = (pending >> rr_ptr) | (pending << (NREQ_W - {1'b0, rr_ptr}));
    scan      = pend_rot;
    sel_valid = 1'b0;
    sel_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_valid && scan[0]) begin
        sel_valid = 1'b1;
        sel_off   = PW'(k);
      end
      scan = scan >> 1;
    end
    sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
    if (sel_sum >= NREQ_W) sel_sum = sel_sum - NREQ_W;
    sel_idx = sel_sum[PW-1:0];
  end

  // Next-state logic; the grant step runs in IDLE and on the last gap cycle,
  // so back-to-back triggers are spaced exactly 1+LEN+GAP cycles.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    grant_next     = grant;
    lreq_type_next = lreq_type;
    lreq_data_next = lreq_data;
    rr_ptr_next    = rr_ptr;
    can_grant      = 1'b0;
    case (state)
      S_IDLE: can_grant = 1'b1;
      S_ISSUE: begin
        cnt_next   = len_m1(lreq_type);
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == 5'd0) begin
          if (GAP == 0) begin
            can_grant = 1'b1;
          end else begin
            cnt_next   = GAP_M1;
            state_next = S_GAP;
          end
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      S_GAP: begin
        if (cnt == 5'd0) can_grant = 1'b1;
        else             cnt_next = cnt - 5'd1;
      end
      default: state_next = S_IDLE;
    endcase
    if (can_grant) begin
      if (sel_valid) begin
        grant_next     = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
        lreq_type_next = slot_type[sel_idx];
        lreq_data_next = slot_data[sel_idx];
        rr_ptr_next    = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        state_next     = S_ISSUE;
      end else begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    end
  end

  assign grant_fire = can_grant & sel_valid;
  assign lreq_trig  = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  // Per-slot latch: a new pulse sets pending and overwrites the slot; set wins over grant clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      logic take;
      assign take          = grant_fire && (sel_idx == PW'(gi));
      assign pend_next[gi] = req_trig[gi] | (pending[gi] & ~take);
      assign ovr_hit[gi]   = req_trig[gi] & pending[gi] & ~take;
      assign type_next[gi] = req_trig[gi] ? req_type[3*gi +: 3]   : slot_type[gi];
      assign data_next[gi] = req_trig[gi] ? req_data[12*gi +: 12] : slot_data[gi];
    end
  endgenerate

  // Control registers: state, counter, grant, presented request and rr pointer.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grant     <= '0;
      lreq_type <= '0;
      lreq_data <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      grant     <= grant_next;
      lreq_type <= lreq_type_next;
      lreq_data <= lreq_data_next;
      rr_ptr    <= rr_ptr_next;
    end
  end

  // Request latches and the sticky overrun flag (a new overrun beats ovr_clr).
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      slot_type <= '{default: '0};
      slot_data <= '{default: '0};
      overrun   <= 1'b0;
    end else begin
      pending   <= pend_next;
      slot_type <= type_next;
      slot_data <= data_next;
      overrun   <= (overrun & ~ovr_clr) | (|ovr_hit);
    end
  end

`ifdef LREQ_ARB_STATS_EN
  logic [7:0] wait_cnt  [NREQ];
  logic [7:0] wait_next [NREQ];

  // Per-slot wait: counts cycles spent pending, restarts at each grant.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wait
      assign wait_next[gi] = g_slot[gi].take ? 8'd0 :
                             (pending[gi] && wait_cnt[gi] != 8'hFF) ? wait_cnt[gi] + 8'd1 :
                             wait_cnt[gi];
    end
  endgenerate

  // Statistics: saturating trigger count and worst-case wait seen at grant.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '{default: '0};
      grant_cnt <= '0;
      max_wait  <= '0;
    end else begin
      wait_cnt <= wait_next;
      if (ovr_clr) begin
        grant_cnt <= '0;
        max_wait  <= '0;
      end else begin
        if (lreq_trig && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
        if (grant_fire && wait_cnt[sel_idx] > max_wait) max_wait <= wait_cnt[sel_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_lreq_arbiter.sv
// Self-checking bench for lreq_arbiter: scoreboard of expected triggers
// (type, data, grant, cycle) pushed at stimulus time, popped on lreq_trig.
module tb_lreq_arbiter;
  localparam int NREQ = 3;

  logic              sysclk;
  logic              reset;
  logic [NREQ-1:0]   req_trig;
  logic [3*NREQ-1:0] req_type;
  logic [12*NREQ-1:0] req_data;
  logic              lreq_trig;
  logic [2:0]        lreq_type;
  logic [11:0]       lreq_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   pending;
  logic              busy;
  logic              overrun;
  logic              ovr_clr;
`ifdef LREQ_ARB_STATS_EN
  logic [15:0]       grant_cnt;
  logic [7:0]        max_wait;
`endif

  lreq_arbiter #(.NREQ(NREQ)) dut (
    .sysclk(sysclk), .reset(reset),
    .req_trig(req_trig), .req_type(req_type), .req_data(req_data),
    .lreq_trig(lreq_trig), .lreq_type(lreq_type), .lreq_data(lreq_data),
    .grant(grant), .pending(pending), .busy(busy), .overrun(overrun),
    .ovr_clr(ovr_clr)
`ifdef LREQ_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .max_wait(max_wait)
`endif
  );

  typedef struct {
    logic [2:0]      t;
    logic [11:0]     d;
    logic [NREQ-1:0] g;
    int              c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0;
  int   n;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [2:0] t, input logic [11:0] d, input int idx, input int c);
    exp_t e;
    e.t = t;
    e.d = d;
    e.g = NREQ'(1) << idx;
    e.c = c;
    sb.push_back(e);
  endtask

  // Called at a negedge: drive one-cycle pulse, return at the next negedge.
  task automatic pulse(input logic [NREQ-1:0] m, input logic [3*NREQ-1:0] t, input logic [12*NREQ-1:0] d);
    req_trig = m;
    req_type = t;
    req_data = d;
    @(negedge sysclk);
    req_trig = '0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sysclk);
  endtask

  // Monitor: every trigger must match the head of the scoreboard.
  always @(negedge sysclk) begin
    if (reset && lreq_trig) begin
      $display("trig cyc=%0d grant=%b type=%0d data=%h", cyc, grant, lreq_type, lreq_data);
      if (sb.size() == 0) begin
        check_eq("spurious_trig", 32'(lreq_trig), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("trig_cyc",  32'(cyc),       32'(mon_e.c));
        check_eq("trig_type", 32'(lreq_type), 32'(mon_e.t));
        check_eq("trig_data", 32'(lreq_data), 32'(mon_e.d));
        check_eq("trig_gnt",  32'(grant),     32'(mon_e.g));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    req_trig = '0;
    req_type = '0;
    req_data = '0;
    ovr_clr  = 1'b0;
    repeat (3) @(negedge sysclk);
    check_eq("rst_trig",    32'(lreq_trig), 32'd0);
    check_eq("rst_type",    32'(lreq_type), 32'd0);
    check_eq("rst_data",    32'(lreq_data), 32'd0);
    check_eq("rst_grant",   32'(grant),     32'd0);
    check_eq("rst_pending", 32'(pending),   32'd0);
    check_eq("rst_busy",    32'(busy),      32'd0);
    check_eq("rst_overrun", 32'(overrun),   32'd0);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // Round robin: three simultaneous requests, type 0.
    c0 = cyc;
    push_exp(3'd0, 12'h100, 0, c0 + 2);
    push_exp(3'd0, 12'h101, 1, c0 + 15);
    push_exp(3'd0, 12'h102, 2, c0 + 28);
    pulse(3'b111, {3'd0, 3'd0, 3'd0}, {12'h102, 12'h101, 12'h100});
    check_eq("rr_pend0", 32'(pending), 32'b111);
    wait_cyc(c0 + 2);
    check_eq("rr_pend1", 32'(pending), 32'b110);
    wait_cyc(c0 + 15);
    check_eq("rr_pend2", 32'(pending), 32'b100);
    wait_cyc(c0 + 28);
    check_eq("rr_pend3", 32'(pending), 32'b000);
    wait_cyc(c0 + 42);
    check_eq("rr_idle", 32'(busy), 32'd0);
`ifdef LREQ_ARB_STATS_EN
    check_eq("grant_cnt", 32'(grant_cnt), 32'd3);
    check_eq("max_wait",  32'(max_wait),  32'd26);
`endif

    // Fairness: requester 0 re-pulses after each grant, 2 re-pulses after its grant.
    c0 = cyc;
    push_exp(3'd0, 12'h200, 0, c0 + 2);
    push_exp(3'd0, 12'h2A0, 2, c0 + 15);
    pulse(3'b101, {3'd0, 3'd0, 3'd0}, {12'h2A0, 12'h000, 12'h200});
    wait_cyc(c0 + 2);
    push_exp(3'd0, 12'h201, 0, c0 + 28);
    pulse(3'b001, {3'd0, 3'd0, 3'd0}, {12'h000, 12'h000, 12'h201});
    wait_cyc(c0 + 15);
    push_exp(3'd0, 12'h2A1, 2, c0 + 41);
    pulse(3'b100, {3'd0, 3'd0, 3'd0}, {12'h2A1, 12'h000, 12'h000});
    wait_cyc(c0 + 28);
    push_exp(3'd0, 12'h202, 0, c0 + 54);
    pulse(3'b001, {3'd0, 3'd0, 3'd0}, {12'h000, 12'h000, 12'h202});
    wait_cyc(c0 + 68);
    check_eq("fair_idle",  32'(busy),    32'd0);
    check_eq("fair_noovr", 32'(overrun), 32'd0);

    // Single request: req 1, type 2 (register write), data ABC.
    c0 = cyc;
    push_exp(3'd2, 12'hABC, 1, c0 + 2);
    pulse(3'b010, {3'd0, 3'd2, 3'd0}, {12'h000, 12'hABC, 12'h000});
    check_eq("single_pend", 32'(pending), 32'b010);
    check_eq("single_lat",  32'(busy),    32'd0);
    wait_cyc(c0 + 2);
    check_eq("single_gnt",  32'(grant),   32'b010);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge sysclk);
    end
    check_eq("busy_len",    32'(n),         32'd23);
    check_eq("single_gnt0", 32'(grant),     32'd0);
    check_eq("type_held",   32'(lreq_type), 32'd2);

    // Overrun: two pulses on req 2 while req 0 is being serviced.
    c0 = cyc;
    push_exp(3'd0, 12'h300, 0, c0 + 2);
    pulse(3'b001, {3'd0, 3'd0, 3'd0}, {12'h000, 12'h000, 12'h300});
    wait_cyc(c0 + 4);
    pulse(3'b100, {3'd0, 3'd0, 3'd0}, {12'h001, 12'h000, 12'h000});
    wait_cyc(c0 + 6);
    push_exp(3'd0, 12'h002, 2, c0 + 15);
    pulse(3'b100, {3'd0, 3'd0, 3'd0}, {12'h002, 12'h000, 12'h000});
    check_eq("ovr_set",  32'(overrun), 32'd1);
    check_eq("ovr_pend", 32'(pending), 32'b100);
    wait_cyc(c0 + 30);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge sysclk);
    ovr_clr = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 32'd0);

    // Reset mid-SHIFT: 5 cycles after the trigger.
    c0 = cyc;
    push_exp(3'd1, 12'h5A5, 1, c0 + 2);
    pulse(3'b010, {3'd0, 3'd1, 3'd0}, {12'h000, 12'h5A5, 12'h000});
    wait_cyc(c0 + 7);
    #1 reset = 1'b0;
    #1;
    check_eq("arst_busy",  32'(busy),      32'd0);
    check_eq("arst_grant", 32'(grant),     32'd0);
    check_eq("arst_type",  32'(lreq_type), 32'd0);
    check_eq("arst_data",  32'(lreq_data), 32'd0);
    check_eq("arst_trig",  32'(lreq_trig), 32'd0);
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    repeat (40) @(negedge sysclk);
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
